// File: rtl/pipelined_ripple_adder_if.sv
// Handshake and operand/result bundle for the segmented add/subtract pipeline.
// The unit is the slave; its producer/consumer side is the master.
interface pipelined_ripple_adder_if #(
  parameter int unsigned WIDTH = 16
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A1;
  logic [WIDTH-1:0] B1;
  logic             CI;
  logic             SUB;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S1;
  logic             CO;
  logic             OV;

  modport slave (
    input  in_valid, A1, B1, CI, SUB, out_ready,
    output in_ready, out_valid, S1, CO, OV
  );

  modport master (
    output in_valid, A1, B1, CI, SUB, out_ready,
    input  in_ready, out_valid, S1, CO, OV
  );
endinterface

// File: rtl/pipelined_ripple_adder.sv
// WIDTH-bit add/subtract built from SEG-bit ripple segments, one register stage per
// segment with the carry registered in between; valid/ready handshake with backpressure.
module pipelined_ripple_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned SEG   = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  pipelined_ripple_adder_if.slave adder_io
);
  localparam int unsigned STAGES = WIDTH / SEG;

  // word_q[k]: bits below (k+1)*SEG are finished sum, bits above are still operand A
  logic [WIDTH-1:0]  word_q [STAGES];
  logic [WIDTH-1:0]  word_d [STAGES];
  logic [WIDTH-1:0]  opb_q  [STAGES];
  logic [WIDTH-1:0]  opb_d  [STAGES];
  logic [WIDTH-1:0]  stg_a  [STAGES];
  logic [WIDTH-1:0]  stg_b  [STAGES];
  logic [STAGES-1:0] stg_c;
  logic [STAGES-1:0] stg_v;
  logic [STAGES-1:0] carry_q;
  logic [STAGES-1:0] carry_d;
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] valid_d;
  logic              ov_q;
  logic              ov_d;
  logic              stall;

  assign stall = valid_q[STAGES-1] && !adder_io.out_ready;

  // Stage inputs: operand prep for stage 0, previous stage registers otherwise
  always_comb begin
    stg_c = '0;
    stg_v = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      stg_a[k] = '0;
      stg_b[k] = '0;
    end
    stg_a[0] = adder_io.A1;
    stg_b[0] = adder_io.SUB ? ~adder_io.B1 : adder_io.B1;
    stg_c[0] = adder_io.SUB ^ adder_io.CI;
    stg_v[0] = adder_io.in_valid;
    for (int unsigned k = 1; k < STAGES; k++) begin
      stg_a[k] = word_q[k-1];
      stg_b[k] = opb_q[k-1];
      stg_c[k] = carry_q[k-1];
      stg_v[k] = valid_q[k-1];
    end
  end

  // Full-adder ripple across each stage's own segment
  always_comb begin
    logic c;
    logic c_msb;
    logic a_b;
    logic b_b;
    c       = 1'b0;
    c_msb   = 1'b0;
    a_b     = 1'b0;
    b_b     = 1'b0;
    carry_d = '0;
    valid_d = stg_v;
    ov_d    = 1'b0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      word_d[k] = stg_a[k];
      opb_d[k]  = stg_b[k];
      c         = stg_c[k];
      for (int unsigned i = 0; i < SEG; i++) begin
        a_b = stg_a[k][k*SEG+i];
        b_b = stg_b[k][k*SEG+i];
        if (k*SEG+i == WIDTH-1) c_msb = c;
        word_d[k][k*SEG+i] = a_b ^ b_b ^ c;
        c = (a_b & b_b) | (c & (a_b ^ b_b));
      end
      carry_d[k] = c;
    end
    ov_d = c_msb ^ carry_d[STAGES-1];
  end

  // Whole pipe freezes on stall; a stage's data loads only with a valid op so outputs hold over bubbles
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        word_q[k] <= '0;
        opb_q[k]  <= '0;
      end
      carry_q <= '0;
      valid_q <= '0;
      ov_q    <= 1'b0;
    end else if (!stall) begin
      valid_q <= valid_d;
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (valid_d[k]) begin
          word_q[k]  <= word_d[k];
          opb_q[k]   <= opb_d[k];
          carry_q[k] <= carry_d[k];
        end
      end
      if (valid_d[STAGES-1]) ov_q <= ov_d;
    end
  end

  assign adder_io.in_ready  = !stall;
  assign adder_io.out_valid = valid_q[STAGES-1];
  assign adder_io.S1        = word_q[STAGES-1];
  assign adder_io.CO        = carry_q[STAGES-1];
  assign adder_io.OV        = ov_q;

endmodule
